// File: rtl/ecdh_sequencer.sv
// ECDH request sequencer: runs k*G then k*Q on one point multiplier via start/done.
// Optional per-job watchdog enabled by defining ECDH_TIMEOUT_EN.
module ecdh_sequencer #(
    parameter int unsigned TO_CYCLES = 4096,
    parameter int unsigned TO_W      = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [13:0] base_point,
    input  logic [13:0] peer_point,
    input  logic [6:0]  priv_key,
    output logic        busy,
    output logic        valid,
    output logic [1:0]  err,
    output logic [13:0] pub_key,
    output logic [13:0] shared,
    output logic [13:0] pm_point,
    output logic [6:0]  pm_scalar,
    output logic        pm_start,
    input  logic [13:0] pm_result,
    input  logic        pm_done
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LAUNCH,
        ARM,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_nx;
    logic        phase;
    logic [13:0] g_r, q_r;
    logic [6:0]  k_r;
    logic        k_zero, pt_zero, to_hit;

    if ((64'd1 << TO_W) <= 64'(TO_CYCLES)) begin : g_to_w_check
        $error("TO_W too narrow for TO_CYCLES");
    end

    assign k_zero  = (k_r == '0);
    assign pt_zero = (g_r == '0) || (q_r == '0);

`ifdef ECDH_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Counter reads 0 in ARM, so the last allowed ARM/WAIT cycle holds TO_CYCLES-1.
    assign to_hit = (to_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == LAUNCH) begin
            to_cnt <= '0;
        end else if (state == ARM || state == WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = CHECK;
            CHECK:   state_nx = (k_zero || pt_zero) ? RESP : LAUNCH;
            LAUNCH:  state_nx = ARM;
            ARM:     state_nx = WAIT;
            WAIT: begin
                if (pm_done) begin
                    state_nx = phase ? RESP : LAUNCH;
                end else if (to_hit) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            g_r     <= '0;
            q_r     <= '0;
            k_r     <= '0;
            err     <= 2'b00;
            pub_key <= '0;
            shared  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        g_r     <= base_point;
                        q_r     <= peer_point;
                        k_r     <= priv_key;
                        phase   <= 1'b0;
                        err     <= 2'b00;
                        pub_key <= '0;
                        shared  <= '0;
                    end
                end
                CHECK: begin
                    if (k_zero) begin
                        err <= 2'b01;
                    end else if (pt_zero) begin
                        err <= 2'b10;
                    end
                end
                WAIT: begin
                    if (pm_done) begin
                        if (!phase) begin
                            pub_key <= pm_result;
                            phase   <= 1'b1;
                        end else begin
                            shared <= pm_result;
                        end
                    end else if (to_hit) begin
                        err     <= 2'b11;
                        pub_key <= '0;
                        shared  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign valid     = (state == RESP);
    assign pm_start  = (state == LAUNCH);
    assign pm_point  = phase ? q_r : g_r;
    assign pm_scalar = k_r;

endmodule

// File: tb/tb_ecdh_sequencer.sv
// Scoreboard bench for ecdh_sequencer with a mock point multiplier of configurable latency.
module tb_ecdh_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [13:0] base_point = '0;
    logic [13:0] peer_point = '0;
    logic [6:0]  priv_key = '0;
    logic        busy, valid, pm_start;
    logic [1:0]  err;
    logic [13:0] pub_key, shared, pm_point;
    logic [6:0]  pm_scalar;
    logic [13:0] pm_result = '0;
    logic        pm_done = 1'b0;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ecdh_sequencer #(.TO_CYCLES(64), .TO_W(13)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .base_point(base_point), .peer_point(peer_point), .priv_key(priv_key),
        .busy(busy), .valid(valid), .err(err), .pub_key(pub_key), .shared(shared),
        .pm_point(pm_point), .pm_scalar(pm_scalar), .pm_start(pm_start),
        .pm_result(pm_result), .pm_done(pm_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {logic [1:0] err; logic [13:0] pub; logic [13:0] sh;} resp_t;
    typedef struct {logic [13:0] pt; logic [6:0] k;} job_t;
    resp_t respq[$];
    job_t  jobq[$];

    // Stand-in for the real multiplier: any fixed function of (k, P) will do.
    function automatic logic [13:0] pmul(logic [6:0] k, logic [13:0] p);
        logic [20:0] prod;
        prod = p * k;
        return prod[13:0] ^ {3'b000, p[13:3]} ^ {k, k};
    endfunction

    // Mock multiplier: done rises lat cycles after ARM; sticky keeps it high until ARM of the next job.
    bit          sticky = 0, no_done = 0, mact = 0, drop_next = 0;
    int unsigned lat = 5, mcnt = 0, last_start = 0, nstarts = 0;
    logic [13:0] mpt;
    logic [6:0]  mk;

    always @(negedge clk) begin
        if (!rst_n) begin
            mact = 0; drop_next = 0; pm_done = 1'b0;
        end else if (pm_start) begin
            job_t j;
            last_start = cyc;
            nstarts++;
            if (jobq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pm_start actual=1 required=0 (t=%0t)", $time);
            end else begin
                j = jobq.pop_front();
                chk("pm_point", pm_point, j.pt);
                chk("pm_scalar", pm_scalar, j.k);
            end
            mpt = pm_point; mk = pm_scalar; mcnt = lat; mact = !no_done; drop_next = 1;
        end else if (drop_next) begin
            pm_done = 1'b0; drop_next = 0;
        end else if (mact) begin
            if (mcnt <= 1) begin
                chk("pm_point_stable", pm_point, mpt);
                pm_done = 1'b1; pm_result = pmul(mk, mpt); mact = 0;
            end else begin
                mcnt--;
            end
        end else if (!sticky) begin
            pm_done = 1'b0;
        end
    end

    int unsigned valid_cyc = 0;
    bit prev_valid = 0;

    always @(negedge clk) begin
        if (valid) begin
            resp_t r;
            valid_cyc = cyc;
            chk("busy_at_valid", busy, 1);
            if (respq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
                r = respq.pop_front();
                chk("err", err, r.err);
                chk("pub_key", pub_key, r.pub);
                chk("shared", shared, r.sh);
            end
        end
        if (prev_valid) begin
            chk("valid_one_cycle", valid, 0);
            chk("busy_falls", busy, 0);
        end
        prev_valid = valid;
    end

    task automatic chk_reset();
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pm_start", pm_start, 0);
        chk("rst_err", err, 0);
        chk("rst_pub_key", pub_key, 0);
        chk("rst_shared", shared, 0);
        chk("rst_pm_point", pm_point, 0);
        chk("rst_pm_scalar", pm_scalar, 0);
    endtask

    function automatic void expect_req(logic [13:0] g, logic [13:0] q, logic [6:0] k);
        resp_t r;
        job_t  j;
        if (k == 0) begin
            r.err = 2'b01; r.pub = '0; r.sh = '0;
        end else if (g == 0 || q == 0) begin
            r.err = 2'b10; r.pub = '0; r.sh = '0;
        end else begin
            j.pt = g; j.k = k; jobq.push_back(j);
            j.pt = q; jobq.push_back(j);
            r.err = 2'b00; r.pub = pmul(k, g); r.sh = pmul(k, q);
        end
        respq.push_back(r);
    endfunction

    // Called at a negedge with the DUT idle; returns in cycle 2 after acceptance.
    task automatic issue(logic [13:0] g, logic [13:0] q, logic [6:0] k);
        bit bad;
        bad = (k == 0) || (g == 0) || (q == 0);
        expect_req(g, q, k);
        base_point = g; peer_point = q; priv_key = k; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        base_point = 14'($urandom); peer_point = 14'($urandom); priv_key = 7'($urandom);
        chk("busy_cycle1", busy, 1);
        @(negedge clk);
        chk("valid_cycle2", valid, bad);
        chk("pm_start_cycle2", pm_start, !bad);
    endtask

    task automatic wait_done(int unsigned budget);
        bit done;
        done = 0;
        for (int unsigned i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (respq.size() == 0) && !busy;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL completion_timeout actual=pending%0d required=0 (t=%0t)", respq.size(), $time);
            respq.delete(); jobq.delete();
        end
    endtask

    localparam logic [13:0] TP_G = 14'b11101111000001;
    localparam logic [6:0]  TP_K = 7'b1001011;

    initial begin
        int unsigned n0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        lat = 40;
        issue(TP_G, TP_G, TP_K);
        wait_done(300);

        lat = 5;
        issue(14'h1234, 14'h0abc, 7'h00);
        wait_done(20);
        issue(14'h0000, 14'h0abc, 7'h07);
        wait_done(20);
        issue(14'h1234, 14'h0000, 7'h05);
        wait_done(20);
        issue(14'h0000, 14'h0000, 7'h00);
        wait_done(20);

        sticky = 1; lat = 1;
        issue(14'h2f0d, 14'h11c3, 7'h5a);
        wait_done(100);
        issue(14'h0777, 14'h3001, 7'h33);
        wait_done(100);
        sticky = 0;
        repeat (2) @(negedge clk);

        lat = 30;
        issue(14'h1a2b, 14'h3c4d, 7'h29);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset();
        respq.delete(); jobq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n0 = nstarts;
        repeat (50) @(negedge clk);
        chk("no_start_after_reset", nstarts, n0);
        chk("idle_after_reset", busy, 0);
        lat = 7;
        issue(14'h1a2b, 14'h3c4d, 7'h29);
        wait_done(200);

        expect_req(14'h0101, 14'h0202, 7'h00);
        expect_req(14'h0101, 14'h0202, 7'h00);
        base_point = 14'h0101; peer_point = 14'h0202; priv_key = 7'h00; req = 1'b1;
        repeat (3) @(negedge clk);
        chk("req_ignored_in_resp", busy, 0);
        @(negedge clk);
        chk("req_resampled_in_idle", busy, 1);
        req = 1'b0;
        wait_done(20);

        for (int i = 0; i < 20; i++) begin
            logic [13:0] g, q;
            logic [6:0]  k;
            g = ($urandom_range(0, 7) == 0) ? 14'h0 : 14'($urandom);
            q = ($urandom_range(0, 7) == 0) ? 14'h0 : 14'($urandom);
            k = ($urandom_range(0, 7) == 0) ? 7'h0 : 7'($urandom);
            lat = $urandom_range(1, 20);
            sticky = ($urandom_range(0, 3) == 0);
            issue(g, q, k);
            wait_done(200);
        end
        sticky = 0;
        repeat (2) @(negedge clk);

`ifdef ECDH_TIMEOUT_EN
        begin
            resp_t r;
            job_t  j;
            no_done = 1;
            j.pt = 14'h0f0f; j.k = 7'h11; jobq.push_back(j);
            r.err = 2'b11; r.pub = '0; r.sh = '0; respq.push_back(r);
            base_point = 14'h0f0f; peer_point = 14'h3131; priv_key = 7'h11; req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            wait_done(200);
            chk("timeout_latency", valid_cyc - last_start, 65);
            no_done = 0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecdh_sequencer.md
# ecdh_sequencer

Host-side controller that drives the GF(2^7) point multiplier through its start/done handshake to perform one ECDH exchange per request. Given a base point G, a peer public point Q and a private scalar k, it issues k·G (own public key) and then k·Q (shared secret) as two back-to-back multiplier jobs. It validates inputs, captures results, and reports status to the host. It sits between the host/key-management logic and a single multiplier instance.

## Interface
- TO_CYCLES, 4096: watchdog limit, in cycles, per multiplier job. Only used when ECDH_TIMEOUT_EN is defined.
- TO_W, 13: width of the watchdog counter. Must satisfy 2^TO_W > TO_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  host request; sampled only in IDLE
- base_point  in  14  G; [13:7]=y, [6:0]=x
- peer_point  in  14  Q; same packing as base_point
- priv_key  in  7  scalar k
- busy  out  1  high from the cycle after acceptance until the valid cycle, inclusive
- valid  out  1  one-cycle completion pulse
- err  out  2  00 ok, 01 k==0, 10 G or Q == 14'h0000 (point at infinity), 11 timeout
- pub_key  out  14  k·G
- shared  out  14  k·Q
- pm_point  out  14  multiplier point operand
- pm_scalar  out  7  multiplier scalar operand
- pm_start  out  1  one-cycle start pulse to the multiplier
- pm_result  in  14  multiplier result
- pm_done  in  1  multiplier done

## Operation
- States: IDLE, CHECK, LAUNCH, ARM, WAIT, RESP. A `phase` bit selects the job: 0 = k·G, 1 = k·Q.
- IDLE, req=1: latch G, Q and k; clear phase; go to CHECK. req is ignored in every other state.
- CHECK:
  - k==0: err=01, go to RESP.
  - Else G==0 or Q==0: err=10, go to RESP.
  - Else: go to LAUNCH.
  - The k check takes priority over the point check.
- LAUNCH:
  - pm_start=1 for exactly one cycle.
  - pm_point = phase ? Q : G; pm_scalar = k.
  - Clear the watchdog; go to ARM.
- ARM: one dead cycle; pm_done is ignored. The multiplier must drop a stale done within one cycle of pm_start.
- WAIT, pm_done=1:
  - phase 0: capture pm_result into pub_key, set phase=1, go to LAUNCH.
  - phase 1: capture pm_result into shared, go to RESP.
- RESP: valid=1 for one cycle, then IDLE. pub_key, shared and err hold until the next acceptance.
- pm_point and pm_scalar hold stable from LAUNCH through WAIT of the same job.
- On any error, pub_key and shared are driven to 14'h0000.

## Timing
- Reset (async assert, sync release): state=IDLE, phase=0. Outputs busy, valid, pm_start = 0; err = 00; pub_key, shared, pm_point = 14'h0000; pm_scalar = 7'h00.
- Reset mid-job: abort immediately. No pm_start is issued after reset release until a new req arrives.
- Acceptance: req sampled in IDLE at edge 0. busy=1 from cycle 1; CHECK in cycle 1; first pm_start in cycle 2.
- Per job: pm_start in cycle s; ARM in s+1; WAIT from s+2. If pm_done is first high in cycle d ≥ s+2, capture at edge d. The next LAUNCH or RESP occupies cycle d+1.
- Error path: valid in cycle 2; no pm_start is ever issued.
- Ok path: valid in the cycle after the second capture. busy falls in the cycle after valid.
- req held high through RESP does not retrigger in the RESP cycle. It is re-sampled in the following IDLE cycle.

## Configuration
- ECDH_TIMEOUT_EN defined:
  - A TO_W-bit counter increments in every ARM/WAIT cycle.
  - Reaching TO_CYCLES without pm_done gives err=11, pub_key=shared=0, then RESP.
  - A late pm_done is ignored while in IDLE.
- ECDH_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; err=11 is never produced.

## Test plan
- G=14'b11101111000001, Q=G, k=7'b1001011, with a behavioural multiplier model (done 40 cycles after start) -> two pm_start pulses with pm_point G then Q; pub_key == shared == model(k,G); err=00; valid 1 cycle.
- k=0 with valid points -> valid in cycle 2, err=01, pm_start never asserted, pub_key=shared=0.
- G=14'h0000, k=7'h07 -> err=10, no pm_start.
- Model holds pm_done=1 from a previous job -> ARM ignores it; capture happens only on the new done.
- rst_n pulsed low during the first WAIT -> all outputs at reset values; no further pm_start; a fresh req completes correctly.
- ECDH_TIMEOUT_EN defined, TO_CYCLES=64, model never asserts done -> err=11 and valid exactly 64 WAIT/ARM cycles after pm_start.
